// File: rtl/seg16_pkg.sv
// seg16_pkg
//   Shared definitions for the 16-segment scrolling display path.
//   - SEG_BLANK      : all segments off (segments are active-low)
//   - GLYPH_*        : active-low segment patterns for the supported characters
//   - seg16_font()   : ASCII byte -> active-low 16-segment pattern; any code
//                      without a glyph maps to SEG_BLANK
package seg16_pkg;

    localparam logic [15:0] SEG_BLANK   = 16'hFFFF;

    localparam logic [15:0] GLYPH_SPACE = 16'hFFFF;
    localparam logic [15:0] GLYPH_C     = 16'h30FF;
    localparam logic [15:0] GLYPH_O     = 16'h00FF;
    localparam logic [15:0] GLYPH_Y     = 16'hFFD5;
    localparam logic [15:0] GLYPH_A     = 16'h0C3F;
    localparam logic [15:0] GLYPH_P     = 16'h1C3F;
    localparam logic [15:0] GLYPH_M     = 16'hCCD7;
    localparam logic [15:0] GLYPH_H     = 16'hCC3F;
    localparam logic [15:0] GLYPH_LC_A  = 16'hF1BD;
    localparam logic [15:0] GLYPH_LC_N  = 16'hFDBD;
    localparam logic [15:0] GLYPH_LC_D  = 16'hC77D;

    function automatic logic [15:0] seg16_font(input logic [7:0] code);
        logic [15:0] seg;
        seg = SEG_BLANK;
        case (code)
            8'h20:   seg = GLYPH_SPACE;  // ' '
            8'h43:   seg = GLYPH_C;      // 'C'
            8'h4F:   seg = GLYPH_O;      // 'O'
            8'h59:   seg = GLYPH_Y;      // 'Y'
            8'h41:   seg = GLYPH_A;      // 'A'
            8'h50:   seg = GLYPH_P;      // 'P'
            8'h4D:   seg = GLYPH_M;      // 'M'
            8'h48:   seg = GLYPH_H;      // 'H'
            8'h61:   seg = GLYPH_LC_A;   // 'a'
            8'h6E:   seg = GLYPH_LC_N;   // 'n'
            8'h64:   seg = GLYPH_LC_D;   // 'd'
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg16_char_fifo.sv
// seg16_char_fifo
//   Synchronous first-word-fall-through FIFO for the character stream.
//   Ports:
//     clk, rst     clock, synchronous active-high reset (pointers/level only)
//     push         write push_data at tail (ignored when full)
//     push_data    character to store
//     pop          discard head entry (ignored when empty)
//     head_data    current head entry, valid when !empty
//     level        entries currently stored, 0..DEPTH
//     full, empty  level == DEPTH / level == 0
module seg16_char_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage carries no reset; only the occupancy bookkeeping does.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/seg16_scroll_sink.sv
// seg16_scroll_sink
//   Accepts ASCII characters over valid/ready, buffers them, and on every
//   scroll tick shifts the four 16-segment displays one place left, bringing
//   the decoded FIFO head in on the right (LEDd).
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     char_data    ASCII character, transferred when char_valid && char_ready
//     char_valid   char_data valid
//     char_ready   sink can accept (low during reset and when FIFO full)
//     scroll_en    1: tick counter runs; 0: counter and display frozen
//     fifo_level   characters currently buffered
//     LEDa..LEDd   active-low segment patterns, LEDa leftmost, LEDd newest
module seg16_scroll_sink
    import seg16_pkg::*;
#(
    parameter int TICK_DIV         = 8388608,
    parameter int FIFO_DEPTH       = 8,
    parameter int BLANK_WHEN_EMPTY = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      char_data,
    input  logic                            char_valid,
    output logic                            char_ready,
    input  logic                            scroll_en,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic [15:0]                     LEDa,
    output logic [15:0]                     LEDb,
    output logic [15:0]                     LEDc,
    output logic [15:0]                     LEDd
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick_p0;
    logic             shift_p0;
    logic [15:0]      glyph_p0;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       head_char;

    // Ready is based on the registered level only, so a pop in the same
    // cycle never admits a push into a full buffer.
    assign char_ready = !rst && !fifo_full;
    assign push       = char_valid && char_ready;

    assign tick_p0  = scroll_en && (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign pop      = tick_p0 && !fifo_empty;
    assign shift_p0 = pop || (tick_p0 && (BLANK_WHEN_EMPTY != 0));
    assign glyph_p0 = fifo_empty ? SEG_BLANK : seg16_font(head_char);

    seg16_char_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (char_data),
        .pop       (pop),
        .head_data (head_char),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (scroll_en) begin
            tick_cnt <= tick_p0 ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    // ---- stage p0 -> p1: display shift register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            LEDa <= SEG_BLANK;
            LEDb <= SEG_BLANK;
            LEDc <= SEG_BLANK;
            LEDd <= SEG_BLANK;
        end else if (shift_p0) begin
            LEDa <= LEDb;
            LEDb <= LEDc;
            LEDc <= LEDd;
            LEDd <= glyph_p0;
        end
    end

endmodule
